// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
// Captures one left/right PCM pair per sample strobe into a small
// first-word-fall-through FIFO that the HDMI audio packetizer drains.
// Strobes that arrive while the FIFO is full (and nothing is leaving)
// are dropped. Each drop sets a sticky overflow flag and bumps a
// saturating drop counter.
//
// Handshake: the head pair is transferred at a rising edge where
// out_valid && out_ready are both high. out_valid depends only on
// registered occupancy, never on out_ready. Once out_valid is high, the
// head pair holds steady until it is popped.
module audio_sample_fifo #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              audio_stb,
  input  logic [WIDTH-1:0]  audio_l,
  input  logic [WIDTH-1:0]  audio_r,
  input  logic              mute,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_l,
  output logic [WIDTH-1:0]  out_r,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [7:0]        drop_count,
  input  logic              clear_ovf
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage and bookkeeping registers
  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_level;
  logic               r_overflow;
  logic [7:0]         r_drop_count;

  // Decoded control
  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [2*WIDTH-1:0] w_wr_data;
  logic [2*WIDTH-1:0] w_head;

  // The level never exceeds DEPTH, so its MSB set means exactly "full"
  assign w_valid   = (r_level != '0);
  assign w_full    = r_level[ADDR_W];
  assign w_pop     = w_valid & out_ready;
  // A pop in the same cycle frees the slot that a full FIFO needs
  assign w_push    = audio_stb & (~w_full | w_pop);
  assign w_drop    = audio_stb & w_full & ~w_pop;
  assign w_wr_data = mute ? '0 : {audio_l, audio_r};

  // Sample storage: memory is not reset because its contents are don't-care
  // until they are written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // Write pointer wraps naturally modulo the depth
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each completed handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: a push and a pop together leave it unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else if (w_push && !w_pop) begin
      r_level <= r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      r_level <= r_level - 1'b1;
    end
  end

  // Sticky overflow flag: a drop overrides a coincident clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // Saturating drop counter. Clear with a coincident drop restarts at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_count <= '0;
    end else if (w_drop && clear_ovf) begin
      r_drop_count <= 8'd1;
    end else if (w_drop) begin
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end else if (clear_ovf) begin
      r_drop_count <= '0;
    end
  end

  // Fall-through head read, forced to zero while the FIFO is empty
  always_comb begin
    w_head = '0;
    if (w_valid) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign out_valid  = w_valid;
  assign out_l      = w_head[2*WIDTH-1:WIDTH];
  assign out_r      = w_head[WIDTH-1:0];
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo. A queue-based reference model tracks the
// expected contents, the overflow flag and the drop count. All outputs are
// compared against this model every cycle, at the falling edge.
module tb_audio_sample_fifo;

  logic        clk;
  logic        reset_n;
  logic        audio_stb;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        mute;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_ovf;

  // Reference model state
  logic [31:0] exp_q[$];
  logic        m_ovf;
  int          m_drops;

  int n_checks;
  int n_errors;

  audio_sample_fifo #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .audio_stb  (audio_stb),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .mute       (mute),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_l      (out_l),
    .out_r      (out_r),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clear_ovf  (clear_ovf)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        v;
    logic [31:0] head;
    v    = (exp_q.size() != 0);
    head = v ? exp_q[0] : 32'h0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("out_l", {16'b0, out_l}, {16'b0, head[31:16]});
    chk("out_r", {16'b0, out_r}, {16'b0, head[15:0]});
    chk("level", {28'b0, level}, exp_q.size());
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("drop_count", {24'b0, drop_count}, m_drops);
  endtask

  // Drives one clock cycle. The call starts and ends at a falling edge.
  task automatic cycle(input logic stb, input logic [15:0] l, input logic [15:0] r,
                       input logic m, input logic rdy, input logic clr);
    bit pop;
    bit full;
    bit drop;
    audio_stb = stb;
    audio_l   = l;
    audio_r   = r;
    mute      = m;
    out_ready = rdy;
    clear_ovf = clr;
    pop  = (exp_q.size() != 0) && rdy;
    full = (exp_q.size() == 8);
    drop = 1'b0;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (stb) begin
      if (!full || pop) exp_q.push_back(m ? 32'h0 : {l, r});
      else drop = 1'b1;
    end
    if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic rdy);
    cycle(1'b1, l, r, 1'b0, rdy, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    audio_stb = 1'b0;
    audio_l   = '0;
    audio_r   = '0;
    mute      = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_outputs();

    // Single push then pop, with fixed latency checks
    idle(4);
    push(16'h1234, 16'hABCD, 1'b0);
    chk("single_valid", {31'b0, out_valid}, 32'd1);
    chk("single_l", {16'b0, out_l}, 32'h1234);
    chk("single_r", {16'b0, out_r}, 32'hABCD);
    idle(2);
    pop_one();
    chk("single_empty", {31'b0, out_valid}, 32'd0);
    chk("single_level", {28'b0, level}, 32'd0);

    // Fill, then overflow with two extra strobes
    for (int i = 1; i <= 10; i++) push(16'(i), 16'(i + 100), 1'b0);
    chk("fill_level", {28'b0, level}, 32'd8);
    chk("fill_ovf", {31'b0, overflow}, 32'd1);
    chk("fill_drops", {24'b0, drop_count}, 32'd2);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", {16'b0, out_l}, i);
      pop_one();
    end
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Full FIFO: a push coincident with a pop is accepted
    for (int i = 1; i <= 8; i++) push(16'(i), 16'(i + 100), 1'b0);
    push(16'd9, 16'd109, 1'b1);
    chk("full_pp_level", {28'b0, level}, 32'd8);
    chk("full_pp_drops", {24'b0, drop_count}, 32'd2);
    for (int i = 2; i <= 9; i++) begin
      chk("pp_drain_head", {16'b0, out_l}, i);
      pop_one();
    end

    // Clear versus drop
    for (int i = 1; i <= 11; i++) push(16'(i), 16'(i), 1'b0);
    chk("drops_five", {24'b0, drop_count}, 32'd5);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("clear_ovf", {31'b0, overflow}, 32'd0);
    chk("clear_drops", {24'b0, drop_count}, 32'd0);
    cycle(1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_ovf", {31'b0, overflow}, 32'd1);
    chk("clr_drop_cnt", {24'b0, drop_count}, 32'd1);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) push(16'hDEAD, 16'hBEEF, 1'b0);
    chk("drop_saturate", {24'b0, drop_count}, 32'd255);
    while (exp_q.size() != 0) pop_one();

    // Mute and pointer wrap: 20 strobes with interleaved reads
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 16'(i * 3), 16'(i * 7), (i >= 10 && i <= 12), 1'b0, 1'b0);
      if (i >= 10 && i <= 12) chk("mute_zero", {out_l, out_r}, 32'h0);
      pop_one();
    end

    // Reset in the middle of operation
    for (int i = 1; i <= 5; i++) push(16'(i + 40), 16'(i + 50), 1'b0);
    chk("pre_rst_level", {28'b0, level}, 32'd5);
    chk("pre_rst_ovf", {31'b0, overflow}, 32'd1);
    audio_stb = 1'b0;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", {out_l, out_r}, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_drops", {24'b0, drop_count}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    push(16'h00FF, 16'hFF00, 1'b0);
    chk("post_rst_level", {28'b0, level}, 32'd1);
    chk("post_rst_head", {out_l, out_r}, 32'h00FFFF00);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Capture-and-buffer stage directly downstream of the audio sample-rate strobe generator. On every `audio_stb` pulse it latches the current left/right PCM pair (or silence when muted) into a small first-word-fall-through FIFO. The HDMI audio packetizer drains it with a valid/ready handshake. The block absorbs the phase difference between the strobe cadence and packet-slot availability, and reports overflow.

## Interface
Parameters:
- `WIDTH`, 16, bits per channel sample
- `ADDR_W`, 3, FIFO address width; depth = 2^ADDR_W (8)

Ports:
- `clk`  in  1  system clock; same domain as the strobe generator
- `reset_n`  in  1  asynchronous, active-low reset
- `audio_stb`  in  1  one-cycle sample strobe from the sample-rate generator
- `audio_l`  in  WIDTH  left sample, sampled only on `audio_stb`
- `audio_r`  in  WIDTH  right sample, sampled only on `audio_stb`
- `mute`  in  1  when 1, a strobe writes zeros instead of `audio_l`/`audio_r`
- `out_valid`  out  1  FIFO non-empty; head pair presented
- `out_ready`  in  1  consumer accepts head pair this cycle
- `out_l`  out  WIDTH  head left sample; 0 when `out_valid`=0
- `out_r`  out  WIDTH  head right sample; 0 when `out_valid`=0
- `level`  out  ADDR_W+1  current occupancy, 0..2^ADDR_W
- `overflow`  out  1  sticky: a strobe arrived while the FIFO was full
- `drop_count`  out  8  saturating count of dropped strobes (stops at 255)
- `clear_ovf`  in  1  one-cycle request to clear `overflow` and `drop_count`

## Operation
- Storage: 2^ADDR_W entries of {L, R}. Write pointer and read pointer are ADDR_W bits wide and wrap modulo depth. `level` is held as a separate ADDR_W+1-bit register.
- Push: `audio_stb`=1 and (`level` < depth, or a pop occurs in the same cycle). The entry is written at the write pointer, and the write pointer increments.
- Pop: `out_valid`=1 and `out_ready`=1. The read pointer increments.
- Level update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together, or neither: unchanged
- Drop: `audio_stb`=1, `level`=depth and no pop in the same cycle.
  - The new sample is discarded. Existing contents are untouched.
  - `overflow` is set to 1.
  - `drop_count` increments, saturating at 255.
- `clear_ovf`: sets `overflow` to 0 and `drop_count` to 0. If a drop happens in the same cycle, the drop wins: `overflow`=1 and `drop_count`=1.
- Mute is evaluated at strobe time only. Entries already in the FIFO are not affected.
- `out_valid` = (`level` != 0).
- `out_l`/`out_r` = memory[read pointer] gated by `out_valid`. This is a combinational read of registered storage.
- Reset (asynchronous assert, any time, including mid-transfer):
  - pointers = 0, `level` = 0, `out_valid` = 0, `out_l`/`out_r` = 0, `overflow` = 0, `drop_count` = 0.
  - Memory contents are don't-care.
  - The first strobe after deassertion is accepted normally.

## Timing
- Write latency: a strobe at edge N gives `out_valid`=1 and valid data after edge N (visible in cycle N+1) when the FIFO was empty. There is no same-cycle bypass.
- Empty FIFO with `out_ready`=1 and `audio_stb`=1 in the same cycle: no pop occurs. The pair is popped at the earliest in the following cycle.
- Pop completes at the clock edge where `out_valid`&&`out_ready`. The next head appears in the following cycle; sustained throughput is one pair per cycle.
- `level`, `overflow` and `drop_count` are registered and update at the same edge as the push/pop that causes them.
- Full FIFO with `audio_stb` and a pop in the same cycle: the push is accepted, `level` stays at depth, and there is no drop.
- Pointer wrap (7→0) is seamless. Data order is strictly FIFO across the wrap.
- `audio_stb` held high for several cycles counts as one push per cycle. The upstream generator guarantees single-cycle pulses.

## Test plan
- Single push/pop:
  - Stimulus: `audio_l`=16'h1234, `audio_r`=16'hABCD, strobe at cycle 5, `out_ready`=0.
  - Response: `out_valid`=1 from cycle 6 with out=1234/ABCD. Raising `out_ready` at cycle 8 gives `out_valid`=0 in cycle 9 and `level`=0.
- Fill and overflow:
  - Stimulus: 8 strobes with values 1..8, no reads, then 2 more strobes (9, 10).
  - Response: `level`=8, `overflow`=1, `drop_count`=2. Draining yields 1..8 in order; 9 and 10 never appear.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full with 1..8; strobe value 9 together with a pop.
  - Response: `level` stays 8, no drop. The drain sequence is 2..9.
- Mute and wrap:
  - Stimulus: 20 strobes with reads interleaved so `level` ≤ 3; `mute`=1 on strobes 10–12.
  - Response: the output sequence matches the inputs, with zeros in positions 10–12, and is correct across two pointer wraps.
- Clear versus drop:
  - Stimulus: drop_count=5; `clear_ovf` alone.
  - Response: `overflow`=0 and `drop_count`=0 next cycle. A later `clear_ovf` coincident with a drop gives `overflow`=1, `drop_count`=1.
- Reset mid-operation:
  - Stimulus: `level`=5, `overflow`=1; assert `reset_n`=0 between clock edges.
  - Response: all outputs are 0 immediately. After release, a strobe of 16'h00FF/16'hFF00 gives `level`=1 and appears at the head.
